audio_dac_serializer: RTL and testbench

Playback counterpart to the ADC deserializer. Accepts 32-bit samples on a valid/ready interface in the AUD_BCLK domain and buffers them in a small FIFO. On each DAC frame start it serializes one sample MSB-first onto AUD_DACDAT, using the same frame format as the capture path: 32 bits, starting when the LRCK signal goes high. Sits between the sample-processing logic (or, directly, the ADC deserializer's done/digital_signal_out for loopback) and the codec DAC pins.

---
 rtl/audio_dac_serializer.sv | 166 ++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// audio_dac_serializer
//
// Playback path toward the codec DAC. Sample words arrive on a valid/ready
// interface and wait in a small FIFO. Each rising edge of AUD_DACLRCK starts a
// frame: the FIFO head (or zero when the FIFO is empty) is loaded into a shift
// register and sent MSB-first on AUD_DACDAT, one bit per AUD_BCLK period.
// AUD_DACDAT changes on the falling edge of AUD_BCLK, so the codec can sample
// it cleanly on the rising edge.
//
// Ports:
//   AUD_BCLK      in   codec bit clock; all state on posedge, AUD_DACDAT on negedge
//   rst           in   asynchronous reset, active-low
//   sample_in     in   sample word to play (SAMPLE_W bits)
//   sample_valid  in   sample_in valid
//   sample_ready  out  FIFO can accept a word (registered, equals !full)
//   AUD_DACLRCK   in   codec DAC frame clock; rising edge starts a frame
//   AUD_DACDAT    out  serial data to the codec
//   fifo_level    out  FIFO occupancy, 0..FIFO_DEPTH
//   underrun      out  one-cycle pulse when a frame starts with the FIFO empty
//   underrun_cnt  out  saturating count of underruns
//   frame_err     out  sticky; a frame start arrived while a word was mid-shift
// -----------------------------------------------------------------------------
module audio_dac_serializer #(
   parameter int SAMPLE_W   = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 2
) (
   input  logic                AUD_BCLK,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic                AUD_DACLRCK,
   output logic                AUD_DACDAT,
   output logic [ADDR_W:0]     fifo_level,
   output logic                underrun,
   output logic [7:0]          underrun_cnt,
   output logic                frame_err
);

   localparam int              CNT_W      = $clog2(SAMPLE_W);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SAMPLE_W - 1);
   localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   // FIFO storage and pointers; pointers wrap naturally since depth is 2**ADDR_W
   logic [SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_ptr;
   logic [ADDR_W:0]     level_nxt;

   logic                lrck_q;
   logic                rise;
   logic                fifo_empty;
   logic                wr_en;
   logic                rd_en;

   state_t              state;
   logic [SAMPLE_W-1:0] shift_reg;
   logic [CNT_W-1:0]    bit_cnt;

   assign rise       = AUD_DACLRCK & ~lrck_q;
   assign fifo_empty = (fifo_level == '0);
   // sample_ready is the registered !full flag, so a write is never accepted
   // while full even if a pop happens in the same cycle.
   assign wr_en      = sample_valid & sample_ready;
   // The FIFO is only drained by a frame load.
   assign rd_en      = rise & ~fifo_empty;

   always_comb begin
      level_nxt = fifo_level;
      if (wr_en && !rd_en) begin
         level_nxt = fifo_level + 1'b1;
      end else if (!wr_en && rd_en) begin
         level_nxt = fifo_level - 1'b1;
      end
   end

   always_ff @(posedge AUD_BCLK or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         sample_ready <= 1'b1;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_level   <= level_nxt;
         sample_ready <= (level_nxt != LEVEL_FULL);
      end
   end

   // Data storage carries no reset; only the pointers define validity.
   always_ff @(posedge AUD_BCLK) begin
      if (wr_en) begin
         fifo_mem[wr_ptr] <= sample_in;
      end
   end

   // Frame sequencer. lrck_q resets high so an LRCK already high at reset
   // release is not mistaken for a frame start.
   always_ff @(posedge AUD_BCLK or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         lrck_q       <= 1'b1;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
         frame_err    <= 1'b0;
      end else begin
         lrck_q   <= AUD_DACLRCK;
         underrun <= 1'b0;
         if (rise) begin
            // A rise exactly when bit_cnt reaches 0 is a gapless back-to-back
            // frame; any earlier rise abandons the word in flight.
            if (state == SHIFT && bit_cnt != '0) begin
               frame_err <= 1'b1;
            end
            if (fifo_empty) begin
               shift_reg <= '0;
               underrun  <= 1'b1;
               if (underrun_cnt != 8'hFF) begin
                  underrun_cnt <= underrun_cnt + 1'b1;
               end
            end else begin
               shift_reg <= fifo_mem[rd_ptr];
            end
            bit_cnt <= LAST_BIT;
            state   <= SHIFT;
         end else begin
            case (state)
               SHIFT: begin
                  if (bit_cnt != '0) begin
                     shift_reg <= shift_reg << 1;
                     bit_cnt   <= bit_cnt - 1'b1;
                  end else begin
                     state     <= IDLE;
                     shift_reg <= '0;
                  end
               end
               default: begin
                  shift_reg <= '0;
               end
            endcase
         end
      end
   end

   // Launch on the falling edge: bit 31 of a word loaded at posedge k is on
   // the pin from negedge k and sampled by the codec at posedge k+1.
   always_ff @(negedge AUD_BCLK or negedge rst) begin
      if (!rst) begin
         AUD_DACDAT <= 1'b0;
      end else begin
         AUD_DACDAT <= shift_reg[SAMPLE_W-1];
      end
   end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// tb_audio_dac_serializer
//
// Directed and randomized stimulus for audio_dac_serializer. A reference model
// holds the FIFO as a queue of words and the pending serial output as a queue
// of bits; every cycle the model and the DUT outputs are compared.
// -----------------------------------------------------------------------------
module tb_audio_dac_serializer;

   localparam int SAMPLE_W   = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int ADDR_W     = 2;

   logic                AUD_BCLK;
   logic                rst;
   logic [SAMPLE_W-1:0] sample_in;
   logic                sample_valid;
   logic                sample_ready;
   logic                AUD_DACLRCK;
   logic                AUD_DACDAT;
   logic [ADDR_W:0]     fifo_level;
   logic                underrun;
   logic [7:0]          underrun_cnt;
   logic                frame_err;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [31:0] mq[$];     // FIFO contents, head at index 0
   bit          bq[$];     // bits still to be driven for the current word
   bit          m_prev;    // LRCK level seen at the previous posedge
   bit          m_dat;     // bit on AUD_DACDAT after the last negedge
   bit          m_und;
   int          m_ucnt;
   bit          m_ferr;
   int          max_lvl;

   logic [31:0] cap;

   audio_dac_serializer #(
      .SAMPLE_W   (SAMPLE_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (ADDR_W)
   ) dut (
      .AUD_BCLK     (AUD_BCLK),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .AUD_DACLRCK  (AUD_DACLRCK),
      .AUD_DACDAT   (AUD_DACDAT),
      .fifo_level   (fifo_level),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .frame_err    (frame_err)
   );

   initial AUD_BCLK = 1'b0;
   always #5 AUD_BCLK = ~AUD_BCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      bq.delete();
      m_prev  = 1'b1;
      m_dat   = 1'b0;
      m_und   = 1'b0;
      m_ucnt  = 0;
      m_ferr  = 1'b0;
      max_lvl = 0;
   endtask

   // Assert reset for two clocks, check the reset state, release.
   task automatic do_reset();
      rst          = 1'b0;
      sample_valid = 1'b0;
      sample_in    = '0;
      AUD_DACLRCK  = 1'b1;
      repeat (2) @(posedge AUD_BCLK);
      #1;
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ready", 32'(sample_ready), 32'd1);
      chk("rst_dat", 32'(AUD_DACDAT), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      model_reset();
      rst = 1'b1;
   endtask

   // One clock: drive inputs, let the posedge happen, advance the model and
   // compare every output.
   task automatic step(input bit v, input logic [31:0] d, input bit l);
      bit          rise;
      bit          empty;
      bit          acc;
      logic [31:0] w;
      sample_valid = v;
      sample_in    = d;
      AUD_DACLRCK  = l;
      @(posedge AUD_BCLK);
      #1;
      // AUD_DACDAT now shows the bit chosen at the previous posedge
      chk("dacdat", 32'(AUD_DACDAT), 32'(m_dat));

      rise   = l && !m_prev;
      m_prev = l;
      empty  = (mq.size() == 0);
      acc    = v && (mq.size() < FIFO_DEPTH);
      m_und  = 1'b0;
      if (rise) begin
         if (bq.size() != 0) m_ferr = 1'b1;
         bq.delete();
         if (empty) begin
            w     = '0;
            m_und = 1'b1;
            if (m_ucnt < 255) m_ucnt++;
         end else begin
            w = mq.pop_front();
         end
         for (int i = SAMPLE_W - 1; i >= 0; i--) bq.push_back(w[i]);
      end
      if (acc) mq.push_back(d);
      m_dat = (bq.size() != 0) ? bq.pop_front() : 1'b0;
      if (mq.size() > max_lvl) max_lvl = mq.size();

      chk("level", 32'(fifo_level), 32'(mq.size()));
      chk("ready", 32'(sample_ready), 32'(mq.size() < FIFO_DEPTH));
      chk("underrun", 32'(underrun), 32'(m_und));
      chk("ucnt", 32'(underrun_cnt), 32'(m_ucnt));
      chk("ferr", 32'(frame_err), 32'(m_ferr));
   endtask

   task automatic frame(input int per, input int wr_at, input logic [31:0] d);
      for (int i = 0; i < per; i++) step(i == wr_at, d, i < per / 2);
   endtask

   // One rise, then 32 clocks capturing the serial word as the codec sees it.
   task automatic play_word(input string tag, input logic [31:0] expw);
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < 32; i++) begin
         step(1'b0, '0, i < 15);
         cap = {cap[30:0], AUD_DACDAT};
      end
      chk(tag, cap, expw);
   endtask

   initial begin
      rst          = 1'b0;
      sample_valid = 1'b0;
      sample_in    = '0;
      AUD_DACLRCK  = 1'b1;
      cap          = '0;
      model_reset();

      // Reset released with LRCK high: no frame may start
      do_reset();
      repeat (3) step(1'b0, '0, 1'b1);
      chk("no_frame_underrun_cnt", 32'(underrun_cnt), 32'd0);

      // Single known word
      step(1'b0, '0, 1'b0);
      step(1'b1, 32'hA5C3_0F81, 1'b0);
      chk("one_word_level", 32'(fifo_level), 32'd1);
      step(1'b0, '0, 1'b0);
      play_word("word_a5c30f81", 32'hA5C3_0F81);
      repeat (3) step(1'b0, '0, 1'b0);
      chk("trailing_zero", 32'(AUD_DACDAT), 32'd0);
      chk("drained_level", 32'(fifo_level), 32'd0);

      // Fill the FIFO, drop a fifth word, play four frames in order
      for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0);
      chk("full_level", 32'(fifo_level), 32'd4);
      chk("full_ready", 32'(sample_ready), 32'd0);
      step(1'b1, 32'h5, 1'b0);
      chk("dropped_level", 32'(fifo_level), 32'd4);
      play_word("word1", 32'h1);
      play_word("word2", 32'h2);
      play_word("word3", 32'h3);
      play_word("word4", 32'h4);
      step(1'b0, '0, 1'b0);

      // Empty frames: underrun pulses and saturating counter
      frame(32, -1, '0);
      chk("ucnt_first", 32'(underrun_cnt), 32'd1);
      for (int f = 0; f < 300; f++) frame(32, -1, '0);
      chk("ucnt_saturated", 32'(underrun_cnt), 32'd255);

      // Early rise abandons an all-ones word for an all-zeros one
      step(1'b1, 32'hFFFF_FFFF, 1'b0);
      step(1'b1, 32'h0, 1'b0);
      step(1'b0, '0, 1'b1);
      for (int i = 1; i < 10; i++) step(1'b0, '0, i < 5);
      chk("ones_before_abort", 32'(AUD_DACDAT), 32'd1);
      step(1'b0, '0, 1'b1);
      chk("ferr_set", 32'(frame_err), 32'd1);
      step(1'b0, '0, 1'b1);
      chk("zero_after_abort", 32'(AUD_DACDAT), 32'd0);
      for (int i = 2; i < 40; i++) step(1'b0, '0, i < 16);

      // Gapless stream: one write per 32-clock frame, written on the rise
      do_reset();
      step(1'b0, '0, 1'b0);
      for (int f = 0; f < 10; f++) frame(32, 0, $urandom);
      repeat (4) step(1'b0, '0, 1'b0);
      chk("stream_max_level", 32'(max_lvl), 32'd1);
      chk("stream_ferr", 32'(frame_err), 32'd0);

      // Random traffic with jittered frame periods, some shorter than a word
      for (int f = 0; f < 40; f++) begin
         int per;
         per = int'($urandom_range(26, 40));
         for (int i = 0; i < per; i++) step($urandom_range(0, 3) == 0, $urandom, i < per / 2);
      end
      repeat (40) step(1'b0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
